// File: rtl/axi4_mem_slave_pkg.sv
// Shared constants, FSM state types and burst legality check for the AXI4 memory responder.
package axi4_mem_pkg;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;
  typedef enum logic       {RD_IDLE, RD_DATA}          rd_state_e;

  // A burst is rejected as a whole when its beat size exceeds the bus or a WRAP length is illegal.
  function automatic logic burst_bad(input logic [2:0] size, input logic [7:0] len,
                                     input logic [1:0] burst, input logic [2:0] max_size);
    return (size > max_size) ||
           ((burst == WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

endpackage

// File: rtl/axi4_mem_slave_if.sv
// AXI4 channel bundles: shared address channel (AW/AR), write data, write response, read data.
interface AXI4_A_IF #(parameter int ID_WIDTH = 4, parameter int ADDR_WIDTH = 32);
  logic                  avalid;
  logic                  aready;
  logic [ID_WIDTH-1:0]   aid;
  logic [ADDR_WIDTH-1:0] aaddr;
  logic [7:0]            alen;
  logic [2:0]            asize;
  logic [1:0]            aburst;
  modport master (output avalid, aid, aaddr, alen, asize, aburst, input aready);
  modport slave  (input avalid, aid, aaddr, alen, asize, aburst, output aready);
endinterface

interface AXI4_W_IF #(parameter int DATA_WIDTH = 64);
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  modport master (output wvalid, wdata, wstrb, wlast, input wready);
  modport slave  (input wvalid, wdata, wstrb, wlast, output wready);
endinterface

interface AXI4_B_IF #(parameter int ID_WIDTH = 4);
  logic                bvalid;
  logic                bready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  modport master (input bvalid, bid, bresp, output bready);
  modport slave  (output bvalid, bid, bresp, input bready);
endinterface

interface AXI4_R_IF #(parameter int ID_WIDTH = 4, parameter int DATA_WIDTH = 64);
  logic                  rvalid;
  logic                  rready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  modport master (input rvalid, rid, rdata, rresp, rlast, output rready);
  modport slave  (output rvalid, rid, rdata, rresp, rlast, input rready);
endinterface

// File: rtl/axi4_mem_slave_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi4_burst_addr_gen
  import axi4_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            asize_i,
  input  logic [7:0]            alen_i,
  input  logic [1:0]            aburst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_WIDTH'(1) << asize_i;
    incr      = addr_i + step;
    // Wrap window is the (alen+1)<<asize byte span aligned to its own size.
    wrap_mask = ((ADDR_WIDTH'(alen_i) + ADDR_WIDTH'(1)) << asize_i) - ADDR_WIDTH'(1);
    case (aburst_i)
      INCR:    next_addr_o = incr;
      WRAP:    next_addr_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
      default: next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 scratch memory responder: independent write and read FSMs over one word array.
module axi4_mem_slave
  import axi4_mem_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 1024
) (
  input logic     aclk,
  input logic     areset,
  AXI4_A_IF.slave aw_if,
  AXI4_W_IF.slave w_if,
  AXI4_B_IF.slave b_if,
  AXI4_A_IF.slave ar_if,
  AXI4_R_IF.slave r_if
);
  localparam int         STRB_WIDTH = DATA_WIDTH / 8;
  localparam int         OFF        = $clog2(STRB_WIDTH);
  localparam int         IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE   = 3'(OFF);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 64'(a) < (64'(MEM_DEPTH) * 64'(STRB_WIDTH));
  endfunction

  // ---------------- write path ----------------
  wr_state_e             wr_state_q, wr_state_d;
  logic [ID_WIDTH-1:0]   wid_q;
  logic [ADDR_WIDTH-1:0] waddr_q, wr_next_addr;
  logic [7:0]            wlen_q, wbeat_q;
  logic [2:0]            wsize_q;
  logic [1:0]            wburst_q;
  logic                  wbad_q, werr_q;
  logic                  aw_ready, w_ready, b_valid;
  logic                  aw_hs, w_hs, wr_last, w_beat_err;
  logic [IDX_W-1:0]      widx;

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr_gen (
    .addr_i(waddr_q), .asize_i(wsize_q), .alen_i(wlen_q), .aburst_i(wburst_q),
    .next_addr_o(wr_next_addr)
  );

  assign aw_hs      = aw_ready && aw_if.avalid;
  assign w_hs       = w_ready && w_if.wvalid;
  assign wr_last    = (wbeat_q == wlen_q);
  assign w_beat_err = wbad_q || !in_range(waddr_q);
  assign widx       = waddr_q[OFF +: IDX_W];

  always_comb begin
    wr_state_d = wr_state_q;
    aw_ready   = 1'b0;
    w_ready    = 1'b0;
    b_valid    = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        aw_ready = 1'b1;
        if (aw_if.avalid) wr_state_d = WR_DATA;
      end
      WR_DATA: begin
        w_ready = 1'b1;
        if (w_if.wvalid && wr_last) wr_state_d = WR_RESP;
      end
      WR_RESP: begin
        b_valid = 1'b1;
        if (b_if.bready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
    // Outputs are forced low for the whole reset cycle, not just after the edge.
    if (areset) begin
      wr_state_d = WR_IDLE;
      aw_ready   = 1'b0;
      w_ready    = 1'b0;
      b_valid    = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= WR_IDLE;
      wid_q      <= '0;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wsize_q    <= '0;
      wburst_q   <= '0;
      wbeat_q    <= '0;
      wbad_q     <= 1'b0;
      werr_q     <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      if (aw_hs) begin
        wid_q    <= aw_if.aid;
        waddr_q  <= aw_if.aaddr;
        wlen_q   <= aw_if.alen;
        wsize_q  <= aw_if.asize;
        wburst_q <= aw_if.aburst;
        wbeat_q  <= '0;
        wbad_q   <= burst_bad(aw_if.asize, aw_if.alen, aw_if.aburst, MAX_SIZE);
        werr_q   <= 1'b0;
      end
      if (w_hs) begin
        werr_q <= werr_q | w_beat_err | (w_if.wlast != wr_last);
        if (!wr_last) begin
          wbeat_q <= wbeat_q + 8'd1;
          waddr_q <= wr_next_addr;
        end
      end
    end
  end

  assign aw_if.aready = aw_ready;
  assign w_if.wready  = w_ready;
  assign b_if.bvalid  = b_valid;
  assign b_if.bid     = b_valid ? wid_q : '0;
  assign b_if.bresp   = (b_valid && werr_q) ? SLVERR : OKAY;

  // ---------------- read path ----------------
  rd_state_e             rd_state_q, rd_state_d;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [ADDR_WIDTH-1:0] raddr_q, rd_next_addr, rd_load_addr;
  logic [7:0]            rlen_q, rbeat_q;
  logic [2:0]            rsize_q;
  logic [1:0]            rburst_q;
  logic                  rbad_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  ar_ready, r_valid;
  logic                  ar_hs, r_hs, rd_last, rd_load, rd_load_err;
  logic [IDX_W-1:0]      ridx;

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr_gen (
    .addr_i(raddr_q), .asize_i(rsize_q), .alen_i(rlen_q), .aburst_i(rburst_q),
    .next_addr_o(rd_next_addr)
  );

  assign ar_hs   = ar_ready && ar_if.avalid;
  assign r_hs    = r_valid && r_if.rready;
  assign rd_last = (rbeat_q == rlen_q);
  assign rd_load = ar_hs || (r_hs && !rd_last);

  always_comb begin
    rd_state_d   = rd_state_q;
    ar_ready     = 1'b0;
    r_valid      = 1'b0;
    rd_load_addr = rd_next_addr;
    rd_load_err  = rbad_q || !in_range(rd_next_addr);
    case (rd_state_q)
      RD_IDLE: begin
        ar_ready     = 1'b1;
        rd_load_addr = ar_if.aaddr;
        rd_load_err  = burst_bad(ar_if.asize, ar_if.alen, ar_if.aburst, MAX_SIZE) ||
                       !in_range(ar_if.aaddr);
        if (ar_if.avalid) rd_state_d = RD_DATA;
      end
      RD_DATA: begin
        r_valid = 1'b1;
        if (r_if.rready && rd_last) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
    if (areset) begin
      rd_state_d = RD_IDLE;
      ar_ready   = 1'b0;
      r_valid    = 1'b0;
    end
  end

  assign ridx = rd_load_addr[OFF +: IDX_W];

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state_q <= RD_IDLE;
      rid_q      <= '0;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rsize_q    <= '0;
      rburst_q   <= '0;
      rbeat_q    <= '0;
      rbad_q     <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      if (ar_hs) begin
        rid_q    <= ar_if.aid;
        raddr_q  <= ar_if.aaddr;
        rlen_q   <= ar_if.alen;
        rsize_q  <= ar_if.asize;
        rburst_q <= ar_if.aburst;
        rbeat_q  <= '0;
        rbad_q   <= burst_bad(ar_if.asize, ar_if.alen, ar_if.aburst, MAX_SIZE);
      end else if (r_hs && !rd_last) begin
        rbeat_q <= rbeat_q + 8'd1;
        raddr_q <= rd_next_addr;
      end
      if (rd_load) begin
        rdata_q <= rd_load_err ? '0 : mem_q[ridx];
        rresp_q <= rd_load_err ? SLVERR : OKAY;
      end
    end
  end

  // Storage has no reset; a same-cycle read above sees the pre-write word.
  always_ff @(posedge aclk) begin
    if (w_hs && !w_beat_err) begin
      for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
        if (w_if.wstrb[i]) mem_q[widx][i*8 +: 8] <= w_if.wdata[i*8 +: 8];
      end
    end
  end

  assign ar_if.aready = ar_ready;
  assign r_if.rvalid  = r_valid;
  assign r_if.rid     = r_valid ? rid_q : '0;
  assign r_if.rdata   = r_valid ? rdata_q : '0;
  assign r_if.rresp   = r_valid ? rresp_q : OKAY;
  assign r_if.rlast   = r_valid && rd_last;

endmodule
